// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake with a two-entry skid buffer, sync flush and bubble-gated control.
// Optional back-pressure/flush counters are built only when EXMEM_PERF_CNT_EN is defined.
module ex_mem_pipe_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic                  ex_regwrite_i,
  input  logic                  ex_memtoreg_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_memwrite_i,
  input  logic [REG_ADDR_W-1:0] ex_rdaddr_i,
  input  logic [DATA_W-1:0]     ex_furesult_i,
  input  logic [DATA_W-1:0]     ex_rtdata_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_regwrite_o,
  output logic                  mem_memtoreg_o,
  output logic                  mem_memread_o,
  output logic                  mem_memwrite_o,
  output logic [REG_ADDR_W-1:0] mem_rdaddr_o,
  output logic [DATA_W-1:0]     mem_furesult_o,
  output logic [DATA_W-1:0]     mem_rtdata_o
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

  // Payload layout, MSB first: regwrite, memtoreg, memread, memwrite, rdaddr, furesult, rtdata.
  localparam int PW = 4 + REG_ADDR_W + 2 * DATA_W;

  // Handshake: a beat moves when valid and ready are both high at a rising clock edge.
  // The producer side sees ready as a pure register output (no combinational path from mem_ready_i).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  occ_state_e    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic [PW-1:0] in_pl;
  logic          accept, fire;

  assign in_pl = {ex_regwrite_i, ex_memtoreg_i, ex_memread_i, ex_memwrite_i,
                  ex_rdaddr_i, ex_furesult_i, ex_rtdata_i};

  assign ex_ready_o  = (state_q != ST_FULL);
  assign mem_valid_o = (state_q != ST_EMPTY);
  assign accept      = ex_valid_i & ex_ready_o;
  assign fire        = mem_valid_o & mem_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Payload registers keep their contents so data outputs hold while invalid.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_pl;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            main_d = in_pl;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_pl;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign mem_regwrite_o = main_q[PW-1] & mem_valid_o;
  assign mem_memtoreg_o = main_q[PW-2] & mem_valid_o;
  assign mem_memread_o  = main_q[PW-3] & mem_valid_o;
  assign mem_memwrite_o = main_q[PW-4] & mem_valid_o;
  assign mem_rdaddr_o   = main_q[2*DATA_W +: REG_ADDR_W];
  assign mem_furesult_o = main_q[DATA_W +: DATA_W];
  assign mem_rtdata_o   = main_q[0 +: DATA_W];

`ifdef EXMEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_valid_o && !mem_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    // Flushing an already-empty stage is not counted.
    if (flush_i && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: directed scenarios plus random traffic against a queue-based model.
// Counter checks run when EXMEM_PERF_CNT_EN is defined (counters instantiated 4 bits wide).
module tb_ex_mem_pipe_stage;
  localparam int DATA_W = 16;
  localparam int RA_W   = 3;
  localparam int CNT_W  = 4;
  localparam int PW     = 4 + RA_W + 2 * DATA_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              flush = 1'b0, ex_valid = 1'b0, mem_ready = 1'b0;
  logic              regwrite = 1'b0, memtoreg = 1'b0, memread = 1'b0, memwrite = 1'b0;
  logic [RA_W-1:0]   rdaddr = '0;
  logic [DATA_W-1:0] furesult = '0, rtdata = '0;
  logic              ex_ready, mem_valid;
  logic              m_regwrite, m_memtoreg, m_memread, m_memwrite;
  logic [RA_W-1:0]   m_rdaddr;
  logic [DATA_W-1:0] m_furesult, m_rtdata;
`ifdef EXMEM_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_regwrite_i(regwrite), .ex_memtoreg_i(memtoreg),
    .ex_memread_i(memread), .ex_memwrite_i(memwrite),
    .ex_rdaddr_i(rdaddr), .ex_furesult_i(furesult), .ex_rtdata_i(rtdata),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_regwrite_o(m_regwrite), .mem_memtoreg_o(m_memtoreg),
    .mem_memread_o(m_memread), .mem_memwrite_o(m_memwrite),
    .mem_rdaddr_o(m_rdaddr), .mem_furesult_o(m_furesult), .mem_rtdata_o(m_rtdata)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  // scoreboard: entries held by the stage, oldest first, plus the entry last presented to MEM
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_front;
  int            stall_m, flush_m;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [PW-1:0] in_pl();
    return {regwrite, memtoreg, memread, memwrite, rdaddr, furesult, rtdata};
  endfunction

  task automatic compare_outputs();
    logic [PW-1:0] cur;
    logic          v;
    v   = (exp_q.size() > 0);
    cur = v ? exp_q[0] : last_front;
    check("mem_valid", 64'(mem_valid), 64'(v));
    check("ex_ready", 64'(ex_ready), 64'(exp_q.size() < 2));
    check("ctrl", 64'({m_regwrite, m_memtoreg, m_memread, m_memwrite}),
          v ? 64'(cur[PW-1 -: 4]) : 64'(0));
    check("rdaddr", 64'(m_rdaddr), 64'(cur[2*DATA_W +: RA_W]));
    check("furesult", 64'(m_furesult), 64'(cur[DATA_W +: DATA_W]));
    check("rtdata", 64'(m_rtdata), 64'(cur[0 +: DATA_W]));
`ifdef EXMEM_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    check("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
  endtask

  // Advance one cycle: update the model with inputs as seen at the edge, then compare at the negedge.
  task automatic tick();
    bit acc, fir;
    @(posedge clk);
    fir = (exp_q.size() > 0) && mem_ready;
    acc = ex_valid && (exp_q.size() < 2);
    if ((exp_q.size() > 0) && !mem_ready && stall_m < CNT_MAX) stall_m++;
    if (flush && (exp_q.size() > 0) && flush_m < CNT_MAX) flush_m++;
    if (flush) exp_q.delete();
    else begin
      if (fir) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_pl());
    end
    @(negedge clk);
    if (exp_q.size() > 0) last_front = exp_q[0];
    compare_outputs();
  endtask

  task automatic drive(input bit v, input bit r, input bit f, input logic [DATA_W-1:0] fu);
    ex_valid  = v;
    mem_ready = r;
    flush     = f;
    {regwrite, memtoreg, memread, memwrite} = 4'($urandom_range(0, 15));
    rdaddr    = RA_W'($urandom_range(0, 7));
    furesult  = fu;
    rtdata    = DATA_W'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_front = '0;
    stall_m    = 0;
    flush_m    = 0;
  endtask

  initial begin
    model_reset();
    // 1: reset values, then idle cycles after release
    repeat (2) @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    drive(0, 0, 0, 16'h0);
    repeat (3) tick();

    // 2: streaming with mem_ready high
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, DATA_W'(i));
      tick();
    end
    drive(0, 1, 0, 16'h0);
    repeat (2) tick();

    // 3: back-pressure, third entry held upstream, then drain in order
    drive(1, 0, 0, 16'hAAAA); tick();
    drive(1, 0, 0, 16'hBBBB); tick();
    drive(1, 0, 0, 16'h3333); tick();
    check("full_ready_low", 64'(ex_ready), 64'(0));
    drive(1, 1, 0, 16'h3333); tick();
    check("drain_first", 64'(m_furesult), 64'(16'hBBBB));
    drive(0, 1, 0, 16'h0);
    repeat (3) tick();

    // 4: flush while FULL with a concurrent valid input
    drive(1, 0, 0, 16'h1111); tick();
    drive(1, 0, 0, 16'h2222); tick();
    drive(1, 0, 1, 16'hCCCC); tick();
    check("flush_valid", 64'(mem_valid), 64'(0));
    check("flush_ready", 64'(ex_ready), 64'(1));
    drive(0, 1, 0, 16'h0);
    repeat (2) tick();
    check("flush_no_cccc", 64'(m_furesult != 16'hCCCC), 64'(1));

    // 5: bubble gating after consumption
    drive(1, 0, 0, 16'h5555);
    {regwrite, memtoreg, memread, memwrite} = 4'b1001;
    rdaddr = 3'd5;
    tick();
    drive(0, 1, 0, 16'h0); tick();
    check("gate_regwrite", 64'(m_regwrite), 64'(0));
    check("gate_memwrite", 64'(m_memwrite), 64'(0));
    check("gate_rdaddr_hold", 64'(m_rdaddr), 64'(5));

    // asynchronous reset mid-cycle with entries in flight
    drive(1, 0, 0, 16'h7777); tick();
    drive(1, 0, 0, 16'h8888); tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 16'h0);
    repeat (2) tick();

`ifdef EXMEM_PERF_CNT_EN
    // 6: stall counter saturation, flush on an empty stage leaves flush count alone
    drive(1, 0, 0, 16'h4242); tick();
    drive(0, 0, 0, 16'h0);
    repeat (20) tick();
    check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    drive(0, 0, 1, 16'h0); tick();
    check("flush_once", 64'(flush_cnt), 64'(1));
    drive(0, 0, 1, 16'h0); tick();
    check("flush_empty", 64'(flush_cnt), 64'(1));
    drive(0, 1, 0, 16'h0); tick();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            DATA_W'($urandom_range(0, 16'hFFFF)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
